// File: rtl/fake_n64_response_sequencer_if.sv
// Reply byte stream from the response sequencer to the tx serializer.
// The master presents tx_byte/tx_last under tx_valid; the slave accepts with tx_ready.
interface fake_n64_response_sequencer_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_byte, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_byte, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/fake_n64_response_sequencer.sv
// Fake N64 controller reply sequencer: decodes rx commands and streams the reply bytes.
// Optional feature: define N64_RUMBLE_EN to map blocks >= 0x8000 to rumble space.
module fake_n64_response_sequencer #(
  parameter int          PAK_AW     = 15,
  parameter logic [7:0]  PAK_STATUS = 8'h01,
  parameter logic [15:0] DEV_ID     = 16'h0500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              handoff_toggle,
  input  logic [7:0]        cmd,
  input  logic [15:0]       address,
  input  logic [7:0]        wr_crc,
  input  logic [31:0]       buttons,
  output logic [PAK_AW-1:0] pak_rd_addr,
  output logic              pak_rd_en,
  input  logic [7:0]        pak_rd_data,
  fake_n64_response_sequencer_if.master tx,
  output logic              busy,
  output logic              overrun,
  output logic              rumble
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SEND_FIX, S_RD_FETCH, S_RD_WAIT, S_RD_SEND, S_SEND_CRC
  } state_t;

  state_t      state;
  logic        sync1, sync2, sync3;
  logic        trigger;
  logic        accept;
  logic [7:0]  cap_cmd;
  logic [10:0] cap_blk;
  logic [7:0]  cap_wr_crc;
  logic [31:0] cap_buttons;
  logic [31:0] fix_sr;
  logic [1:0]  fix_rem;
  logic [4:0]  off;
  logic [7:0]  crc_acc;
  logic        rumble_space;
  logic        unused_addr_chk;

  assign trigger = sync2 ^ sync3;
  assign accept  = tx.tx_valid && tx.tx_ready;
  assign busy    = (state != S_IDLE);
  // The rx path already validated the address checksum bits.
  assign unused_addr_chk = ^address[4:0];

  // One byte of the MSB-first, non-reflected CRC-8 (poly 0x85) shift register.
  function automatic logic [7:0] crc_fold(input logic [7:0] acc, input logic [7:0] din);
    logic [7:0] c;
    c = acc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7]) c = {c[6:0], din[i]} ^ 8'h85;
      else      c = {c[6:0], din[i]};
    end
    return c;
  endfunction

  function automatic logic [PAK_AW-1:0] pak_addr(input logic [10:0] blk, input logic [4:0] o);
    return PAK_AW'({blk, o});
  endfunction

`ifdef N64_RUMBLE_EN
  assign rumble_space = cap_blk[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      rumble <= 1'b0;
    end else if (state == S_LATCH && cap_cmd == 8'h03 && cap_blk == 11'h600) begin
      if (cap_wr_crc == 8'hB8)      rumble <= 1'b1;
      else if (cap_wr_crc == 8'h00) rumble <= 1'b0;
    end
  end
`else
  assign rumble_space = 1'b0;
  assign rumble       = 1'b0;
`endif

  // Command capture and fixed-reply shift register: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && trigger) begin
      cap_cmd     <= cmd;
      cap_blk     <= address[15:5];
      cap_wr_crc  <= wr_crc;
      cap_buttons <= buttons;
    end
    if (state == S_LATCH)
      fix_sr <= (cap_cmd == 8'h01) ? {cap_buttons[23:0], 8'h00} : {DEV_ID[7:0], PAK_STATUS, 16'h0000};
    else if (state == S_SEND_FIX && accept)
      fix_sr <= {fix_sr[23:0], 8'h00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      tx.tx_byte  <= 8'h00;
      tx.tx_valid <= 1'b0;
      tx.tx_last  <= 1'b0;
      pak_rd_en   <= 1'b0;
      pak_rd_addr <= '0;
      overrun     <= 1'b0;
      crc_acc     <= 8'h00;
      off         <= 5'd0;
      fix_rem     <= 2'd0;
    end else begin
      sync1     <= handoff_toggle;
      sync2     <= sync1;
      sync3     <= sync2;
      overrun   <= trigger && (state != S_IDLE);
      pak_rd_en <= 1'b0;
      case (state)
        S_IDLE: if (trigger) state <= S_LATCH;
        S_LATCH: begin
          case (cap_cmd)
            8'h00, 8'hFF: begin
              tx.tx_byte  <= DEV_ID[15:8];
              tx.tx_valid <= 1'b1;
              tx.tx_last  <= 1'b0;
              fix_rem     <= 2'd2;
              state       <= S_SEND_FIX;
            end
            8'h01: begin
              tx.tx_byte  <= cap_buttons[31:24];
              tx.tx_valid <= 1'b1;
              tx.tx_last  <= 1'b0;
              fix_rem     <= 2'd3;
              state       <= S_SEND_FIX;
            end
            8'h02: begin
              off         <= 5'd0;
              crc_acc     <= 8'h00;
              pak_rd_en   <= !rumble_space;
              pak_rd_addr <= pak_addr(cap_blk, 5'd0);
              state       <= S_RD_FETCH;
            end
            8'h03: begin
              tx.tx_byte  <= cap_wr_crc;
              tx.tx_valid <= 1'b1;
              tx.tx_last  <= 1'b1;
              state       <= S_SEND_CRC;
            end
            default: state <= S_IDLE;
          endcase
        end
        S_SEND_FIX: if (accept) begin
          if (fix_rem == 2'd0) begin
            tx.tx_valid <= 1'b0;
            tx.tx_last  <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tx.tx_byte <= fix_sr[31:24];
            tx.tx_last <= (fix_rem == 2'd1);
            fix_rem    <= fix_rem - 2'd1;
          end
        end
        S_RD_FETCH: state <= S_RD_WAIT;
        // Pak data is valid during this cycle (1-clk read latency).
        S_RD_WAIT: begin
          tx.tx_byte  <= rumble_space ? 8'h80 : pak_rd_data;
          tx.tx_valid <= 1'b1;
          tx.tx_last  <= 1'b0;
          state       <= S_RD_SEND;
        end
        S_RD_SEND: if (accept) begin
          crc_acc <= crc_fold(crc_acc, tx.tx_byte);
          if (off == 5'd31) begin
            // Final byte folded plus 8 augmenting zero bits.
            tx.tx_byte <= crc_fold(crc_fold(crc_acc, tx.tx_byte), 8'h00);
            tx.tx_last <= 1'b1;
            state      <= S_SEND_CRC;
          end else begin
            off         <= off + 5'd1;
            tx.tx_valid <= 1'b0;
            pak_rd_en   <= !rumble_space;
            pak_rd_addr <= pak_addr(cap_blk, off + 5'd1);
            state       <= S_RD_FETCH;
          end
        end
        S_SEND_CRC: if (accept) begin
          tx.tx_valid <= 1'b0;
          tx.tx_last  <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fake_n64_response_sequencer.sv
// Scoreboard bench for fake_n64_response_sequencer: expected reply bytes and pak
// addresses are queued at stimulus time and compared as the DUT emits them.
module tb_fake_n64_response_sequencer;
  localparam int PAK_AW = 15;
`ifdef N64_RUMBLE_EN
  localparam bit RUMBLE = 1'b1;
`else
  localparam bit RUMBLE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              handoff_toggle = 1'b0;
  logic [7:0]        cmd = 8'h00;
  logic [15:0]       address = 16'h0000;
  logic [7:0]        wr_crc = 8'h00;
  logic [31:0]       buttons = 32'h0;
  logic [PAK_AW-1:0] pak_rd_addr;
  logic              pak_rd_en;
  logic [7:0]        pak_rd_data = 8'h00;
  logic              busy, overrun, rumble;

  fake_n64_response_sequencer_if tx_if ();

  fake_n64_response_sequencer #(.PAK_AW(PAK_AW)) dut (
    .clk(clk), .reset(reset), .handoff_toggle(handoff_toggle), .cmd(cmd),
    .address(address), .wr_crc(wr_crc), .buttons(buttons),
    .pak_rd_addr(pak_rd_addr), .pak_rd_en(pak_rd_en), .pak_rd_data(pak_rd_data),
    .tx(tx_if), .busy(busy), .overrun(overrun), .rumble(rumble)
  );

  always #5 clk = ~clk;

  logic [7:0]        pak_mem [2**PAK_AW];
  logic [8:0]        sb [$];
  logic [PAK_AW-1:0] addr_q [$];
  int checks = 0, errors = 0;
  int ovr_cnt = 0, rd_cnt = 0, acc_cnt = 0;
  int ready_mode = 0;
  logic       stall_pend = 1'b0;
  logic [9:0] stall_val = '0;

  always @(posedge clk) if (pak_rd_en) pak_rd_data <= pak_mem[pak_rd_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = ~tx_if.tx_ready;
        default: tx_if.tx_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (overrun) ovr_cnt++;
      if (pak_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) check_eq("pak_rd_unexpected", 32'(pak_rd_addr), 32'hFFFF_FFFF);
        else check_eq("pak_rd_addr", 32'(pak_rd_addr), 32'(addr_q.pop_front()));
      end
      if (stall_pend) check_eq("stall_hold", 32'({tx_if.tx_valid, tx_if.tx_last, tx_if.tx_byte}), 32'(stall_val));
      stall_pend = tx_if.tx_valid && !tx_if.tx_ready;
      stall_val  = {1'b1, tx_if.tx_last, tx_if.tx_byte};
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        acc_cnt++;
        if (sb.size() == 0) check_eq("tx_unexpected", 32'({tx_if.tx_last, tx_if.tx_byte}), 32'hFFFF_FFFF);
        else check_eq("tx_byte", 32'({tx_if.tx_last, tx_if.tx_byte}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] a, input logic [7:0] w, input logic [31:0] b);
    @(posedge clk); #1;
    cmd = c; address = a; wr_crc = w; buttons = b;
    handoff_toggle = ~handoff_toggle;
  endtask

  task automatic push_info();
    sb.push_back(9'h005); sb.push_back(9'h000); sb.push_back(9'h101);
  endtask

  task automatic push_buttons(input logic [31:0] b);
    sb.push_back({1'b0, b[31:24]}); sb.push_back({1'b0, b[23:16]});
    sb.push_back({1'b0, b[15:8]});  sb.push_back({1'b1, b[7:0]});
  endtask

  task automatic push_read(input logic [15:0] a);
    logic [7:0]  d [32];
    logic [15:0] a16;
    logic [7:0]  r, t;
    logic        bit_in;
    bit          rs;
    rs = RUMBLE && a[15];
    for (int o = 0; o < 32; o++) begin
      a16  = {a[15:5], 5'(o)};
      d[o] = rs ? 8'h80 : pak_mem[a16[PAK_AW-1:0]];
      if (!rs) addr_q.push_back(a16[PAK_AW-1:0]);
      sb.push_back({1'b0, d[o]});
    end
    r = 8'h00;
    for (int i = 0; i < 33; i++) begin
      for (int j = 7; j >= 0; j--) begin
        bit_in = 1'b0;
        if (i < 32) bit_in = d[i][j];
        t = r[7] ? 8'h85 : 8'h00;
        r = {r[6:0], bit_in} ^ t;
      end
    end
    sb.push_back({1'b1, r});
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while ((sb.size() != 0 || busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) check_eq(tag, 32'({busy, 8'(sb.size())}), 32'h0);
  endtask

  task automatic wait_valid(input int max_cyc);
    int n;
    n = 0;
    while (!tx_if.tx_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!tx_if.tx_valid) check_eq("valid_timeout", 32'(tx_if.tx_valid), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, rd0, acc0, n;
    for (int i = 0; i < 2**PAK_AW; i++) pak_mem[i] = 8'($urandom);
    for (int i = 32'h20; i < 32'h40; i++) pak_mem[i] = 8'h00;

    repeat (3) @(posedge clk); #1;
    check_eq("rst_tx_valid", 32'(tx_if.tx_valid), 32'h0);
    check_eq("rst_tx_last", 32'(tx_if.tx_last), 32'h0);
    check_eq("rst_tx_byte", 32'(tx_if.tx_byte), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);
    check_eq("rst_pak_rd", 32'({pak_rd_en, pak_rd_addr}), 32'h0);
    check_eq("rst_rumble", 32'(rumble), 32'h0);
    reset = 1'b0;

    // INFO commands, free-flowing and with a stalling sink
    push_info(); send_cmd(8'h00, 16'h0000, 8'h00, 32'h0); wait_done("info00_timeout", 200);
    ready_mode = 1;
    push_info(); send_cmd(8'hFF, 16'h0000, 8'h00, 32'h0); wait_done("infoFF_timeout", 200);

    // Button state under alternating ready
    push_buttons(32'h80FF127F); send_cmd(8'h01, 16'h0000, 8'h00, 32'h80FF127F);
    wait_done("buttons_timeout", 200);

    // Pak reads: zeroed block, then random block with stalls
    ready_mode = 0;
    push_read(16'h0020); send_cmd(8'h02, 16'h0020, 8'h00, 32'h0); wait_done("read20_timeout", 1000);
    ready_mode = 1;
    push_read(16'h1234); send_cmd(8'h02, 16'h1234, 8'h00, 32'h0); wait_done("read1234_timeout", 1000);

    // WRITE reply held by the sink while a second command arrives
    ready_mode = 2;
    sb.push_back(9'h15A); send_cmd(8'h03, 16'h0000, 8'h5A, 32'h0);
    wait_valid(50);
    ovr0 = ovr_cnt;
    send_cmd(8'h01, 16'h0000, 8'h00, 32'h11223344);
    repeat (6) @(negedge clk);
    check_eq("overrun_mid_reply", 32'(ovr_cnt - ovr0), 32'h1);
    check_eq("busy_while_stalled", 32'(busy), 32'h1);
    ready_mode = 0;
    wait_done("write5A_timeout", 100);
    repeat (8) @(negedge clk);
    check_eq("idle_after_drop", 32'({busy, tx_if.tx_valid}), 32'h0);

    // Trigger landing on the clock of the final accept
    ready_mode = 2;
    sb.push_back(9'h1C3); send_cmd(8'h03, 16'h0000, 8'hC3, 32'h0);
    wait_valid(50);
    ovr0 = ovr_cnt;
    @(posedge clk); #1; cmd = 8'h00; handoff_toggle = ~handoff_toggle;
    @(posedge clk); #2; ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check_eq("busy_at_final_accept", 32'({busy, tx_if.tx_valid, tx_if.tx_ready}), 32'h7);
    repeat (3) @(negedge clk);
    check_eq("overrun_final_accept", 32'(ovr_cnt - ovr0), 32'h1);
    check_eq("idle_after_final", 32'({busy, 8'(sb.size())}), 32'h0);
    repeat (6) @(negedge clk);

    // Unknown command: LATCH for one clock, nothing emitted
    send_cmd(8'h42, 16'h0000, 8'h00, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("unknown_latch_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_eq("unknown_idle", 32'({busy, tx_if.tx_valid}), 32'h0);

    // Reset in the middle of a READ
    acc0 = acc_cnt;
    push_read(16'h0100); send_cmd(8'h02, 16'h0100, 8'h00, 32'h0);
    n = 0;
    while (acc_cnt - acc0 < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("read_progress", 32'(acc_cnt - acc0 >= 10), 32'h1);
    @(posedge clk); #1; reset = 1'b1; handoff_toggle = 1'b0;
    @(posedge clk); #1;
    check_eq("midreset_tx", 32'({tx_if.tx_valid, tx_if.tx_last}), 32'h0);
    check_eq("midreset_busy", 32'({busy, pak_rd_en}), 32'h0);
    sb.delete(); addr_q.delete();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    push_info(); send_cmd(8'h00, 16'h0000, 8'h00, 32'h0); wait_done("post_reset_timeout", 200);

    // Rumble space read and rumble-motor writes
    rd0 = rd_cnt;
    push_read(16'h8000); send_cmd(8'h02, 16'h8000, 8'h00, 32'h0); wait_done("read8000_timeout", 1000);
    check_eq("rd_cnt_8000", 32'(rd_cnt - rd0), RUMBLE ? 32'd0 : 32'd32);
    sb.push_back(9'h1B8); send_cmd(8'h03, 16'hC000, 8'hB8, 32'h0); wait_done("rumble_on_timeout", 100);
    check_eq("rumble_on", 32'(rumble), 32'(RUMBLE));
    sb.push_back(9'h100); send_cmd(8'h03, 16'hC000, 8'h00, 32'h0); wait_done("rumble_off_timeout", 100);
    check_eq("rumble_off", 32'(rumble), 32'h0);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size() + addr_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
